// File: rtl/ps2_pkg.sv
// Shared constants and frame-state encoding for the PS/2 scan-code receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Movement keys watched by the player FSM
    localparam logic [7:0] KEY_W    = 8'h1D;
    localparam logic [7:0] KEY_S    = 8'h1B;
    localparam logic [7:0] KEY_A    = 8'h1C;
    localparam logic [7:0] KEY_D    = 8'h23;
    localparam logic [7:0] KEY_NONE = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Decoded keyboard outputs; master is the receiver, slave is the game control path.
interface ps2_keycode_rx_if;

    logic [7:0] oByte;
    logic       oByteStrobe;
    logic [7:0] oKeyCode;
    logic       oExtended;
    logic       oKeyPress;
    logic       oFrameErr;

    modport master (
        output oByte, oByteStrobe, oKeyCode, oExtended, oKeyPress, oFrameErr
    );

    modport slave (
        input  oByte, oByteStrobe, oKeyCode, oExtended, oKeyPress, oFrameErr
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame capture,
// odd-parity/stop check and a mid-frame inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [7:0] oByte,
    output logic       oByteStrobe,
    output logic       oFrameErr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   ps2_clk_s, ps2_dat_s, fall, timeout;

    frame_state_t     state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_ok_q, parity_ok_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_d;
    logic             strobe_d, err_d;

    // Pins idle high, so the chains reset to 1 to avoid a phantom edge
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], iPS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], iPS2_DAT};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
    assign fall      = clk_prev & ~ps2_clk_s;
    assign timeout   = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            cnt_q       <= '0;
            oByte       <= '0;
            oByteStrobe <= 1'b0;
            oFrameErr   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
            cnt_q       <= cnt_d;
            oByte       <= byte_d;
            oByteStrobe <= strobe_d;
            oFrameErr   <= err_d;
        end
    end

    // Timeout takes priority over a coincident clock edge
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        cnt_d       = cnt_q;
        byte_d      = oByte;
        strobe_d    = 1'b0;
        err_d       = 1'b0;

        if (state_q == S_IDLE || fall) begin
            cnt_d = '0;
        end else if (!timeout) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!ps2_dat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {ps2_dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    parity_ok_d = ^{shift_q, ps2_dat_s};
                    state_d     = S_STOP;
                end
                S_STOP: begin
                    if (parity_ok_q && ps2_dat_s) begin
                        byte_d   = shift_q;
                        strobe_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 Scan Code Set 2 receiver presenting the held key's make code as a level.
// Define PS2_TYPEMATIC_FILTER_EN to suppress oKeyPress on typematic repeats.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             iClock,
    input  logic             iResetn,
    input  logic             iPS2_CLK,
    input  logic             iPS2_DAT,
    ps2_keycode_rx_if.master bus
);

    logic [7:0] rx_byte;
    logic       rx_strobe, rx_err;
    logic       brk_pend, ext_pend;
    logic [7:0] key_code;
    logic       extended, key_press;
    logic       is_held;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame (
        .iClock      (iClock),
        .iResetn     (iResetn),
        .iPS2_CLK    (iPS2_CLK),
        .iPS2_DAT    (iPS2_DAT),
        .oByte       (rx_byte),
        .oByteStrobe (rx_strobe),
        .oFrameErr   (rx_err)
    );

    assign is_held = (rx_byte == key_code) && (ext_pend == extended);

    // Prefix tracking and held-key register; a new make always replaces the held key
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            key_code  <= KEY_NONE;
            extended  <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (rx_strobe) begin
                if (rx_byte == PS2_BREAK) begin
                    brk_pend <= 1'b1;
                end else if (rx_byte == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (brk_pend) begin
                    if (is_held) begin
                        key_code <= KEY_NONE;
                        extended <= 1'b0;
                    end
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end else begin
                    key_code <= rx_byte;
                    extended <= ext_pend;
                    ext_pend <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
                    key_press <= !is_held;
`else
                    key_press <= 1'b1;
`endif
                end
            end else if (rx_err) begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end
        end
    end

    assign bus.oByte       = rx_byte;
    assign bus.oByteStrobe = rx_strobe;
    assign bus.oFrameErr   = rx_err;
    assign bus.oKeyCode    = key_code;
    assign bus.oExtended   = extended;
    assign bus.oKeyPress   = key_press;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: directed table, corner sequences and a
// randomized byte stream checked against a prefix-queue reference model.
module tb_ps2_keycode_rx;
    import ps2_pkg::*;

    localparam int TIMEOUT = 400;
    localparam int SYNC    = 2;
    localparam int HALF    = 4;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic iClock   = 1'b0;
    logic iResetn  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_dat  = 1'b1;

    ps2_keycode_rx_if bus ();

    ps2_keycode_rx #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .iClock   (iClock),
        .iResetn  (iResetn),
        .iPS2_CLK (ps2_clk),
        .iPS2_DAT (ps2_dat),
        .bus      (bus)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        logic [7:0] data;
        bit         bad;
        logic [7:0] exp_key;
        bit         exp_ext;
        int         press_inc;
    } vec_t;

    vec_t vecs[14];

    int cyc = 0, stop_cyc = 0;
    int n_strobe = 0, n_press = 0, n_err = 0, strobe_cyc = 0, press_cyc = 0;
    int checks = 0, passes = 0;
    int exp_strobe = 0, exp_press = 0, exp_err = 0;
    logic [7:0] good_byte = 8'h00;

    // Reference model state
    logic [7:0] pre_q[$];
    logic [7:0] m_key = 8'h00;
    bit         m_ext = 1'b0;

    always @(posedge iClock) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling system-clock edge
    always @(negedge iClock) begin
        if (bus.oByteStrobe) begin
            n_strobe   <= n_strobe + 1;
            strobe_cyc <= cyc;
        end
        if (bus.oKeyPress) begin
            n_press   <= n_press + 1;
            press_cyc <= cyc;
        end
        if (bus.oFrameErr) n_err <= n_err + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge iClock);
        #1;
    endtask

    task automatic sendBit(input logic b);
        ps2_dat = b;
        waitCycles(HALF);
        ps2_clk  = 1'b0;
        stop_cyc = cyc;
        waitCycles(HALF);
        ps2_clk = 1'b1;
        waitCycles(HALF);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        sendBit(1'b0);
        for (int k = 0; k < 8; k++) sendBit(b[k]);
        sendBit(par);
        sendBit(1'b1);
        waitCycles(6);
    endtask

    task automatic doReset();
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        iResetn = 1'b0;
        waitCycles(3);
        iResetn = 1'b1;
        waitCycles(3);
        pre_q.delete();
        m_key = 8'h00;
        m_ext = 1'b0;
    endtask

    // Prefixes queue up until a plain byte arrives, which consumes them all
    task automatic modelByte(input logic [7:0] b);
        bit has_brk, has_ext, repeat_key;
        if (b == 8'hF0 || b == 8'hE0) begin
            pre_q.push_back(b);
        end else begin
            has_brk = 1'b0;
            has_ext = 1'b0;
            foreach (pre_q[k]) begin
                if (pre_q[k] == 8'hF0) has_brk = 1'b1;
                if (pre_q[k] == 8'hE0) has_ext = 1'b1;
            end
            pre_q.delete();
            repeat_key = (b == m_key) && (has_ext == m_ext);
            if (has_brk) begin
                if (repeat_key) begin
                    m_key = 8'h00;
                    m_ext = 1'b0;
                end
            end else begin
                m_key = b;
                m_ext = has_ext;
                if (!(FILTER && repeat_key)) exp_press++;
            end
        end
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;
        int         sel;

        vecs[0]  = '{8'h1D, 1'b0, 8'h1D, 1'b0, 1};
        vecs[1]  = '{8'hF0, 1'b0, 8'h1D, 1'b0, 0};
        vecs[2]  = '{8'h1D, 1'b0, 8'h00, 1'b0, 0};
        vecs[3]  = '{8'hE0, 1'b0, 8'h00, 1'b0, 0};
        vecs[4]  = '{8'h75, 1'b0, 8'h75, 1'b1, 1};
        vecs[5]  = '{8'hF0, 1'b0, 8'h75, 1'b1, 0};
        vecs[6]  = '{8'h75, 1'b0, 8'h75, 1'b1, 0};
        vecs[7]  = '{8'hE0, 1'b0, 8'h75, 1'b1, 0};
        vecs[8]  = '{8'hF0, 1'b0, 8'h75, 1'b1, 0};
        vecs[9]  = '{8'h75, 1'b0, 8'h00, 1'b0, 0};
        vecs[10] = '{8'h23, 1'b1, 8'h00, 1'b0, 0};
        vecs[11] = '{8'h1C, 1'b0, 8'h1C, 1'b0, 1};
        vecs[12] = '{8'h1C, 1'b0, 8'h1C, 1'b0, FILTER ? 0 : 1};
        vecs[13] = '{8'h1C, 1'b0, 8'h1C, 1'b0, FILTER ? 0 : 1};

        doReset();
        checkOutput("reset_outputs",
                    {bus.oByte, bus.oByteStrobe, bus.oKeyCode, bus.oExtended, bus.oKeyPress, bus.oFrameErr}, 32'h0);

        // A falling edge with data high in idle is not a start bit
        sendBit(1'b1);
        waitCycles(20);
        checkOutput("idle_high_no_err", n_err, exp_err);
        checkOutput("idle_high_no_strobe", n_strobe, exp_strobe);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].data, vecs[i].bad);
            if (vecs[i].bad) exp_err++;
            else begin
                exp_strobe++;
                good_byte = vecs[i].data;
                checkOutput("lat_strobe", strobe_cyc - stop_cyc, SYNC + 1);
            end
            exp_press += vecs[i].press_inc;
            if (vecs[i].press_inc != 0) checkOutput("lat_keycode", press_cyc - strobe_cyc, 1);
            checkOutput("tbl_byte", bus.oByte, good_byte);
            checkOutput("tbl_key", bus.oKeyCode, vecs[i].exp_key);
            checkOutput("tbl_ext", bus.oExtended, vecs[i].exp_ext);
            checkOutput("tbl_strobes", n_strobe, exp_strobe);
            checkOutput("tbl_presses", n_press, exp_press);
            checkOutput("tbl_errs", n_err, exp_err);
        end

        // PS/2 clock stalls after four data bits
        sendBit(1'b0);
        for (int k = 0; k < 4; k++) sendBit(k[0]);
        waitCycles(TIMEOUT - 20);
        checkOutput("timeout_not_early", n_err, exp_err);
        waitCycles(40);
        exp_err++;
        checkOutput("timeout_err", n_err, exp_err);
        checkOutput("timeout_no_strobe", n_strobe, exp_strobe);
        applyStimulus(KEY_S, 1'b0);
        exp_strobe++;
        exp_press++;
        checkOutput("after_timeout_key", bus.oKeyCode, 8'h1B);
        checkOutput("after_timeout_byte", bus.oByte, 8'h1B);
        checkOutput("after_timeout_strobes", n_strobe, exp_strobe);

        // Reset in the middle of a frame
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        iResetn = 1'b0;
        #1;
        checkOutput("midframe_reset_outputs",
                    {bus.oByte, bus.oByteStrobe, bus.oKeyCode, bus.oExtended, bus.oKeyPress, bus.oFrameErr}, 32'h0);
        waitCycles(3);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        iResetn = 1'b1;
        waitCycles(30);
        checkOutput("midframe_no_strobe", n_strobe, exp_strobe);
        checkOutput("midframe_no_err", n_err, exp_err);
        checkOutput("midframe_no_press", n_press, exp_press);
        pre_q.delete();
        m_key     = 8'h00;
        m_ext     = 1'b0;
        good_byte = 8'h00;

        for (int i = 0; i < 40; i++) begin
            sel  = int'($urandom_range(0, 9));
            rbad = 1'b0;
            case (sel)
                0, 1:    rb = 8'hF0;
                2:       rb = 8'hE0;
                3:       rb = KEY_W;
                4:       rb = KEY_S;
                5:       rb = KEY_A;
                6:       rb = KEY_D;
                7:       rb = 8'h75;
                8:       rb = 8'($urandom_range(0, 255));
                default: begin
                    rb   = 8'($urandom_range(0, 255));
                    rbad = 1'b1;
                end
            endcase
            applyStimulus(rb, rbad);
            if (rbad) begin
                exp_err++;
                pre_q.delete();
            end else begin
                exp_strobe++;
                good_byte = rb;
                modelByte(rb);
            end
            checkOutput("rand_byte", bus.oByte, good_byte);
            checkOutput("rand_key", bus.oKeyCode, m_key);
            checkOutput("rand_ext", bus.oExtended, m_ext);
            checkOutput("rand_presses", n_press, exp_press);
            checkOutput("rand_strobes", n_strobe, exp_strobe);
            checkOutput("rand_errs", n_err, exp_err);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
